// File: rtl/detector_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// detector_arbiter_pkg : shared FSM encoding, default parameters and helpers
// rev 1.0
// ---------------------------------------------------------------------------
package detector_arbiter_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_DET_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  // Index width that never collapses to zero for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/detector_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// detector_arbiter_if : requester-side bus of the detector arbiter
// rev 1.0
// ---------------------------------------------------------------------------
interface detector_arbiter_if
  import detector_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
);

  logic [N_REQ-1:0]                req;
  logic [N_REQ*W-1:0]              data;
  logic [N_REQ-1:0]                grant;
  logic                            busy;
  logic                            done;
  logic [idx_width(N_REQ)-1:0]     done_id;
  logic [$clog2(W+1)-1:0]          match_cnt;

  modport master (
    output req, data,
    input  grant, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, data,
    output grant, busy, done, done_id, match_cnt
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick starting after the last winner
// rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import detector_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]            i_req,
  input  logic [idx_width(N_REQ)-1:0] i_last,
  output logic [N_REQ-1:0]            o_grant,
  output logic [idx_width(N_REQ)-1:0] o_idx,
  output logic                        o_valid
);

  localparam int c_idw = idx_width(N_REQ);

  always_comb begin
    int                 w_pos;
    logic [c_idw-1:0]   w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    // Walk the ring once, beginning just past the previous winner.
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos  = (int'(i_last) + k) % N_REQ;
      w_cand = c_idw'(w_pos);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/detector_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// detector_arbiter : serves requesters round-robin through one shared detector
// rev 1.0
// ---------------------------------------------------------------------------
module detector_arbiter
  import detector_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int DET_LAT = DEF_DET_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  detector_arbiter_if.slave  bus,
  output logic               o_det_rst,
  output logic               o_det_x,
  input  logic               i_det_y
);

  localparam int c_idw = idx_width(N_REQ);
  localparam int c_cw  = $clog2(W + 1);
  localparam int c_win = W + DET_LAT;
  localparam int c_ww  = $clog2(c_win + 1);

  state_t              r_state;
  state_t              w_next;

  logic                r_init;
  logic [N_REQ-1:0]    r_onehot;
  logic [c_idw-1:0]    r_idx;
  logic [c_idw-1:0]    r_last;
  logic [c_idw-1:0]    r_done_id;
  logic [W-1:0]        r_shift;
  logic [c_ww-1:0]     r_win;
  logic [c_cw-1:0]     r_acc;
  logic [c_cw-1:0]     r_match;

  logic [N_REQ-1:0]    w_pick_onehot;
  logic [c_idw-1:0]    w_pick_idx;
  logic                w_pick_valid;
  logic [W-1:0]        w_pick_word;
  logic                w_in_window;
  logic                w_win_end;
  logic                w_shift_end;
  logic [c_cw-1:0]     w_acc_next;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_grant (w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_pick_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_onehot[i]) begin
        w_pick_word = bus.data[i*W +: W];
      end
    end
  end

  assign w_in_window = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
  assign w_shift_end = (r_state == ST_SHIFT) && (r_win == c_ww'(W - 1));
  assign w_win_end   = w_in_window && (r_win == c_ww'(c_win - 1));

  // Only the last W window cycles carry detector responses to our own bits.
  always_comb begin
    w_acc_next = r_acc;
    if (w_in_window && (r_win >= c_ww'(DET_LAT)) && i_det_y &&
        (r_acc != c_cw'(W))) begin
      w_acc_next = r_acc + c_cw'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_pick_valid) w_next = ST_CLR;
      ST_CLR:    w_next = ST_SHIFT;
      ST_SHIFT:  if (w_shift_end) w_next = (DET_LAT == 0) ? ST_REPORT : ST_DRAIN;
      ST_DRAIN:  if (w_win_end) w_next = ST_REPORT;
      ST_REPORT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.grant = '0;
    bus.busy  = (r_state != ST_IDLE);
    bus.done  = 1'b0;
    o_det_x   = 1'b0;
    // r_init keeps the detector cleared until the first edge out of reset.
    o_det_rst = r_init;
    unique case (r_state)
      ST_CLR: begin
        bus.grant = r_onehot;
        o_det_rst = 1'b1;
      end
      ST_SHIFT:  o_det_x  = r_shift[W-1];
      ST_REPORT: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.done_id   = r_done_id;
  assign bus.match_cnt = r_match;

  // Job datapath: latched word, window counter and match accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init    <= 1'b1;
      r_onehot  <= '0;
      r_idx     <= '0;
      r_last    <= c_idw'(N_REQ - 1);
      r_done_id <= '0;
      r_shift   <= '0;
      r_win     <= '0;
      r_acc     <= '0;
      r_match   <= '0;
    end else begin
      r_init <= 1'b0;
      r_acc  <= w_acc_next;
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_onehot <= w_pick_onehot;
            r_idx    <= w_pick_idx;
            r_shift  <= w_pick_word;
            r_win    <= '0;
            r_acc    <= '0;
          end
        end
        ST_SHIFT: begin
          r_shift <= r_shift << 1;
          r_win   <= r_win + c_ww'(1);
        end
        ST_DRAIN: r_win <= r_win + c_ww'(1);
        default: ;
      endcase
      if (w_win_end) begin
        r_match   <= w_acc_next;
        r_done_id <= r_idx;
        r_last    <= r_idx;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.grant));

  a_detx_shift_only: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != ST_SHIFT) |-> !o_det_x);

endmodule
`default_nettype wire

// File: tb/tb_detector_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_detector_arbiter : directed scenarios against a job-level reference model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_detector_arbiter;
  import detector_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int L   = 2;
  localparam int JOB = W + L + 2;   // offset of the done cycle from the sample cycle

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  detector_arbiter_if #(.N_REQ(N), .W(W)) ifc ();

  logic         det_rst, det_x, det_y;
  logic [L-1:0] stub_sr    = '0;
  logic         stub_force = 1'b0;

  always @(posedge clk) begin
    if (det_rst) stub_sr <= '0;
    else         stub_sr <= {stub_sr[L-2:0], det_x};
  end
  assign det_y = stub_force | stub_sr[L-1];

  detector_arbiter #(.N_REQ(N), .W(W), .DET_LAT(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .o_det_rst (det_rst),
    .o_det_x   (det_x),
    .i_det_y   (det_y)
  );

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       q_gnt[$];
  int       q_match[$];
  int       q_id[$];
  int       gnt_cyc = -1;
  int       done_cyc = -1;
  int       n_done = 0;
  logic [W-1:0] cap = '0;
  int       cap_n = W;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and per-cycle compare
  initial begin
    bit           m_active, m_fresh, m_force, found;
    int           m_off, m_idx, m_last, m_done_id, m_match, c;
    logic [W-1:0] m_word;
    logic [N-1:0] e_grant;
    logic         e_busy, e_x, e_rst, e_done;
    m_active = 0; m_fresh = 1; m_force = 0; m_off = 0; m_idx = 0;
    m_last = N - 1; m_done_id = 0; m_match = 0; m_word = '0;
    forever begin
      @(negedge clk);
      e_grant = '0; e_busy = 0; e_x = 0; e_done = 0; e_rst = 1;
      if (!rst_n) begin
        m_active = 0; m_last = N - 1; m_done_id = 0; m_match = 0; m_fresh = 1;
      end else begin
        e_rst = m_fresh;
        if (m_active) begin
          e_busy = 1;
          if (m_off == 1) begin
            e_grant = N'(1) << m_idx;
            e_rst   = 1;
          end
          if (m_off >= 2 && m_off <= W + 1) e_x = m_word[W + 1 - m_off];
          if (m_off == JOB) begin
            e_done    = 1;
            m_done_id = m_idx;
            m_match   = m_force ? W : $countones(m_word);
            m_last    = m_idx;
          end
        end
      end
      check("grant",     ifc.grant,     e_grant);
      check("busy",      ifc.busy,      e_busy);
      check("det_x",     det_x,         e_x);
      check("det_rst",   det_rst,       e_rst);
      check("done",      ifc.done,      e_done);
      check("done_id",   ifc.done_id,   m_done_id);
      check("match_cnt", ifc.match_cnt, m_match);

      if (ifc.grant != '0) begin
        for (int i = 0; i < N; i++) if (ifc.grant[i]) q_gnt.push_back(i);
        gnt_cyc = cyc;
        cap_n   = 0;
      end else if (cap_n < W) begin
        cap   = {cap[W-2:0], det_x};
        cap_n = cap_n + 1;
      end
      if (ifc.done) begin
        n_done++;
        done_cyc = cyc;
        q_match.push_back(int'(ifc.match_cnt));
        q_id.push_back(int'(ifc.done_id));
      end

      if (rst_n) begin
        m_fresh = 0;
        if (m_active) begin
          if (m_off == JOB) m_active = 0;
          else              m_off = m_off + 1;
        end else if (ifc.req != '0) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && ifc.req[c]) begin
              found = 1;
              m_idx = c;
            end
          end
          m_word   = ifc.data[m_idx*W +: W];
          m_force  = stub_force;
          m_active = 1;
          m_off    = 1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int b;
    b = 0;
    while (n_done < target && b < budget) begin
      step(1);
      b++;
    end
    check("done_seen", n_done >= target, 1);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int t0, n0;
    int exp_g[5];
    int exp_m[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_m = '{0, 8, 4, 2, 0};
    ifc.req  = '0;
    ifc.data = '0;
    #1 rst_n = 1'b0;
    step(3);
    check("rst_det_rst", det_rst, 1);
    check("rst_busy",    ifc.busy, 0);

    // Single request, word A5
    rst_n = 1'b1;
    ifc.data[7:0] = 8'hA5;
    ifc.req = 4'b0001;
    t0 = cyc; n0 = n_done;
    step(1);
    ifc.req = '0;
    wait_done(n0 + 1, 30);
    check("s1_grant_lat", gnt_cyc - t0, 1);
    check("s1_done_lat",  done_cyc - t0, 12);
    check("s1_det_x",     cap, 8'hA5);
    check("s1_id",        qget(q_id, q_id.size() - 1), 0);
    check("s1_match",     qget(q_match, q_match.size() - 1), 4);

    // All four requesting, fresh arbitration
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    q_gnt.delete(); q_match.delete(); q_id.delete();
    ifc.data = {8'h81, 8'h0F, 8'hFF, 8'h00};
    ifc.req  = 4'b1111;
    n0 = n_done;
    wait_done(n0 + 5, 90);
    ifc.req = '0;
    check("s2_n_grants", q_gnt.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("s2_grant_order", qget(q_gnt, i), exp_g[i]);
      check("s2_match",       qget(q_match, i), exp_m[i]);
    end

    // Late request from 2 while 0 is in service; word 0 altered after grant
    step(2);
    q_gnt.delete(); q_match.delete(); q_id.delete();
    ifc.data = {8'h00, 8'h07, 8'h00, 8'hC3};
    ifc.req  = 4'b0001;
    n0 = n_done;
    step(1);
    ifc.req = '0;
    step(3);
    ifc.data[7:0] = 8'hFF;
    ifc.req = 4'b0100;
    wait_done(n0 + 2, 60);
    ifc.req = '0;
    check("s3_n_grants", q_gnt.size(), 2);
    check("s3_first",    qget(q_gnt, 0), 0);
    check("s3_second",   qget(q_gnt, 1), 2);
    check("s3_match0",   qget(q_match, 0), 4);
    check("s3_match2",   qget(q_match, 1), 3);
    check("s3_id2",      qget(q_id, 1), 2);

    // Reset in the 5th SHIFT cycle aborts the job
    step(2);
    ifc.data[7:0] = 8'hA5;
    ifc.req = 4'b0001;
    step(1);
    ifc.req = '0;
    step(5);
    #2 rst_n = 1'b0;
    n0 = n_done;
    #1;
    check("abort_busy",    ifc.busy, 0);
    check("abort_det_x",   det_x, 0);
    check("abort_det_rst", det_rst, 1);
    check("abort_id",      ifc.done_id, 0);
    check("abort_match",   ifc.match_cnt, 0);
    step(2);
    rst_n = 1'b1;
    step(15);
    check("abort_no_done", n_done, n0);
    ifc.req = 4'b0001;
    t0 = cyc;
    step(1);
    ifc.req = '0;
    wait_done(n0 + 1, 30);
    check("rerun_done_lat", done_cyc - t0, 12);
    check("rerun_match",    qget(q_match, q_match.size() - 1), 4);

    // Detector stuck high over the whole window
    step(2);
    stub_force = 1'b1;
    ifc.data[7:0] = 8'h00;
    ifc.req = 4'b0001;
    n0 = n_done;
    step(1);
    ifc.req = '0;
    wait_done(n0 + 1, 30);
    check("force_match", qget(q_match, q_match.size() - 1), 8);
    stub_force = 1'b0;

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/detector_arbiter.md
DETECTOR_ARBITER -- requirements
Module: detector_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters.
REQ-002 Parameter W, default 8: bits per request word.
REQ-003 Parameter DET_LAT, default 2: cycles from a bit on det_x to its effect on det_y.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  level request per requester; data must be stable while req is high.
REQ-007 data  input  N_REQ*W  request words; requester i occupies slice [i*W +: W].
REQ-008 grant  output  N_REQ  one-hot, one-cycle pulse naming the requester being served.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 det_rst  output  1  active-high synchronous clear to the shared detector.
REQ-011 det_x  output  1  serial bit stream to the detector.
REQ-012 det_y  input  1  detector match output.
REQ-013 done  output  1  one-cycle pulse when a job completes.
REQ-014 done_id  output  clog2(N_REQ)  index of the completed requester; held until the next done.
REQ-015 match_cnt  output  clog2(W+1)  number of det_y highs counted for the completed job; held until the next done.

Function
REQ-016 FSM states and transitions: IDLE -> CLR -> SHIFT -> DRAIN -> REPORT -> IDLE.
REQ-017 IDLE: if any req bit is high, pick the winner round-robin, latch its W-bit word, and move to CLR; otherwise stay in IDLE.
REQ-018 Round-robin: search starts at (last_grant+1) mod N_REQ; last_grant resets to N_REQ-1, so requester 0 wins first.
REQ-019 CLR, 1 cycle: grant = one-hot winner, det_rst = 1, det_x = 0.
REQ-020 SHIFT, W cycles: det_x = latched word, MSB first, one bit per cycle.
REQ-021 DRAIN, DET_LAT cycles: det_x = 0.
REQ-022 Counting window: over the W+DET_LAT cycles of SHIFT plus DRAIN, match_cnt accumulates det_y only in the last W cycles.
REQ-023 match_cnt saturates at W and cannot wrap.
REQ-024 REPORT, 1 cycle: done = 1, done_id and match_cnt updated, last_grant = winner.
REQ-025 Latency: req sampled in IDLE at cycle 0 gives grant at cycle 1 and done at cycle 2+W+DET_LAT (12 with defaults).
REQ-026 Back-to-back: a req still high in the IDLE cycle after REPORT is eligible again, ordered after the other requesters.
REQ-027 req or data changes after the grant cycle have no effect on the job in progress.
REQ-028 Simultaneous requests: exactly one grant per job; a losing req stays pending with no loss and no grant.
REQ-029 Outside CLR, det_rst = 0; outside SHIFT, det_x = 0.
REQ-030 busy = 0 only in IDLE.

Reset
REQ-031 While reset = 0, asynchronously: state = IDLE, grant = 0, busy = 0, det_x = 0, det_rst = 1, done = 0, done_id = 0, match_cnt = 0, last_grant = N_REQ-1.
REQ-032 Reset asserted mid-job aborts the job: no done pulse, and the next job starts from a fresh arbitration.
REQ-033 The first rising edge after reset deassertion leaves det_rst = 0 and the FSM in IDLE.

Structure
REQ-034 Shared package detector_arbiter_pkg holds the FSM state enum and default parameter constants.
REQ-035 Sub-module rr_arbiter contains the combinational round-robin pick (req plus last_grant in, one-hot winner and index out).
REQ-036 Sequencing, shift register and counters stay in detector_arbiter; target 150-300 lines.

Verification
REQ-037 The bench detector stub is det_y = det_x delayed DET_LAT cycles and cleared by det_rst, so match_cnt equals popcount(word).
REQ-038 Scenario: req = 0001, data0 = 8'hA5 -> grant = 0001 at cycle 1; det_x = 1,0,1,0,0,1,0,1; done at cycle 12 with done_id = 0, match_cnt = 4.
REQ-039 Scenario: req = 1111 held, words 8'h00, 8'hFF, 8'h0F, 8'h81 -> grants in order 0,1,2,3,0; match_cnt = 0, 8, 4, 2.
REQ-040 Scenario: req = 0100 arrives during the job for requester 0 -> it is served next, with no lost or duplicated grant.
REQ-041 Scenario: reset pulsed low in the 5th SHIFT cycle -> outputs take reset values immediately, no done; the next req = 0001 completes normally.
REQ-042 Scenario: a stub forcing det_y = 1 for the whole window -> match_cnt = 8 and no wrap.
